// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller and its ALU.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRC_B_RT    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMMSH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath/IR/memory signal bundle; master is the controller side.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] controle;
  logic       branch_eq;
  logic       branch_neq;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output controle, branch_eq, branch_neq, alu_src_a, alu_src_b, pc_src, pc_en,
           iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  controle, branch_eq, branch_neq, alu_src_a, alu_src_b, pc_src, pc_en,
           iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           illegal, state
  );
endinterface

// File: rtl/mc_control_alu_op_decode.sv
// R-type funct field to ALU control code, with a flag for supported functs.
module alu_op_decode
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] controle,
  output logic       valid
);

  always_comb begin
    controle = ALU_ADD;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  controle = ALU_ADD;
      FN_SUB:  controle = ALU_SUB;
      FN_AND:  controle = ALU_AND;
      FN_OR:   controle = ALU_OR;
      FN_SLT:  controle = ALU_SLT;
      FN_NOR:  controle = ALU_NOR;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM (Moore outputs plus mem_ready/zero qualifiers).
// Build option: MC_CTRL_BNE_EN enables decoding of bne; otherwise bne is illegal.
//
// state   | meaning
// FETCH   | read instruction, PC+4 when mem_ready
// DECODE  | branch target into ALUOut, dispatch on opcode
// MEMADR  | compute lw/sw address
// MEMRD   | data read, wait for mem_ready
// MEMWB   | load data into rt
// MEMWR   | data write, wait for mem_ready
// EXEC    | R-type ALU operation
// ALUWB   | R-type result into rd
// BRANCH  | compare rs/rt, load PC when taken
// ADDIEX  | rs + sign-ext imm
// ADDIWB  | addi result into rt
// JUMP    | load jump target
// ILLEGAL | flag unsupported instruction, skip it
module mc_control
  import mc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

`ifdef MC_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic       is_store_q;
  logic [3:0] fn_ctrl;
  logic       fn_valid;
  logic       op_bne;

  alu_op_decode u_alu_op_decode (
    .funct    (bus.funct),
    .controle (fn_ctrl),
    .valid    (fn_valid)
  );

  assign op_bne    = BNE_EN && (bus.opcode == OP_BNE);
  assign bus.state = state_q;

  // lw/sw choice is captured in DECODE so MEMADR does not depend on the IR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) is_store_q <= (bus.opcode == OP_SW);
    end
  end

  always_comb begin
    state_d        = S_FETCH;
    bus.controle   = ALU_ADD;
    bus.branch_eq  = 1'b0;
    bus.branch_neq = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRC_B_RT;
    bus.pc_src     = PC_SRC_ALU;
    bus.pc_en      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRC_B_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_en     = bus.mem_ready;
        state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.alu_src_b = SRC_B_IMMSH;
        if (bus.opcode == OP_RTYPE)
          state_d = fn_valid ? S_EXEC : S_ILLEGAL;
        else if (bus.opcode == OP_LW || bus.opcode == OP_SW)
          state_d = S_MEMADR;
        else if (bus.opcode == OP_BEQ || op_bne)
          state_d = S_BRANCH;
        else if (bus.opcode == OP_ADDI)
          state_d = S_ADDIEX;
        else if (bus.opcode == OP_J)
          state_d = S_JUMP;
        else
          state_d = S_ILLEGAL;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRC_B_IMM;
        state_d       = is_store_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        state_d      = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        state_d       = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.controle  = fn_ctrl;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.controle  = fn_ctrl;
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.controle   = ALU_SUB;
        bus.pc_src     = PC_SRC_ALUOUT;
        bus.branch_eq  = (bus.opcode == OP_BEQ);
        bus.branch_neq = op_bne;
        bus.pc_en      = bus.zero;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRC_B_IMM;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.reg_write = 1'b1;
      end
      S_JUMP: begin
        bus.pc_src = PC_SRC_JUMP;
        bus.pc_en  = 1'b1;
      end
      S_ILLEGAL: begin
        bus.illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control (honours MC_CTRL_BNE_EN if defined).
module tb_mc_control;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mc_control_if bus ();

  mc_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_fetch();
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++; if (bus.controle !== 4'b0010) begin errors++; $display("FAIL reset_controle got %b want 0010", bus.controle); end
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL reset_mem_read got %b want 1", bus.mem_read); end
    checks++; if (bus.alu_src_b !== 2'b01) begin errors++; $display("FAIL reset_alu_src_b got %b want 01", bus.alu_src_b); end
    checks++; if ({bus.reg_write, bus.mem_write, bus.ir_write, bus.pc_en} !== 4'b0011)
      begin errors++; $display("FAIL reset_enables got %b want 0011", {bus.reg_write, bus.mem_write, bus.ir_write, bus.pc_en}); end
    bus.mem_ready = 1'b0;
    #1;
    checks++; if ({bus.ir_write, bus.pc_en} !== 2'b00) begin errors++; $display("FAIL reset_ready_low got %b want 00", {bus.ir_write, bus.pc_en}); end
    bus.mem_ready = 1'b1;
    reset = 1'b0;
    tick();
    checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL reset_to_decode got %0d want 1", bus.state); end
    checks++; if (bus.alu_src_b !== 2'b11) begin errors++; $display("FAIL decode_alu_src_b got %b want 11", bus.alu_src_b); end
  endtask

  task automatic test_fetch_wait();
    go_fetch();
    bus.mem_ready = 1'b0;
    tick();
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL fetch_wait_state got %0d want 0", bus.state); end
    checks++; if ({bus.ir_write, bus.pc_en} !== 2'b00) begin errors++; $display("FAIL fetch_wait_en got %b want 00", {bus.ir_write, bus.pc_en}); end
    bus.mem_ready = 1'b1;
    tick();
    checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL fetch_release got %0d want 1", bus.state); end
  endtask

  task automatic test_rtype();
    go_fetch();
    bus.opcode = 6'b000000; bus.funct = 6'b100111;
    tick();
    tick();
    checks++; if (bus.state !== 4'd6) begin errors++; $display("FAIL rtype_exec_state got %0d want 6", bus.state); end
    checks++; if (bus.controle !== 4'b1100) begin errors++; $display("FAIL rtype_nor_controle got %b want 1100", bus.controle); end
    checks++; if ({bus.alu_src_a, bus.alu_src_b} !== 3'b100) begin errors++; $display("FAIL rtype_exec_src got %b want 100", {bus.alu_src_a, bus.alu_src_b}); end
    tick();
    checks++; if (bus.state !== 4'd7) begin errors++; $display("FAIL rtype_aluwb_state got %0d want 7", bus.state); end
    checks++; if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b110)
      begin errors++; $display("FAIL rtype_aluwb_ctrl got %b want 110", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); end
    checks++; if (bus.controle !== 4'b1100) begin errors++; $display("FAIL rtype_aluwb_controle got %b want 1100", bus.controle); end
    tick();
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL rtype_done got %0d want 0", bus.state); end
    // SLT and an unsupported funct
    bus.funct = 6'b101010;
    tick(); tick();
    checks++; if (bus.controle !== 4'b0111) begin errors++; $display("FAIL rtype_slt_controle got %b want 0111", bus.controle); end
    tick(); tick();
    bus.funct = 6'b000000;
    tick(); tick();
    checks++; if (bus.state !== 4'd12) begin errors++; $display("FAIL rtype_bad_funct got %0d want 12", bus.state); end
    checks++; if ({bus.illegal, bus.reg_write} !== 2'b10) begin errors++; $display("FAIL rtype_bad_illegal got %b want 10", {bus.illegal, bus.reg_write}); end
    tick();
    checks++; if ({bus.state, bus.illegal} !== 5'b00000) begin errors++; $display("FAIL rtype_bad_pulse got %b want 00000", {bus.state, bus.illegal}); end
  endtask

  task automatic test_lw_wait();
    int cyc;
    go_fetch();
    bus.opcode = 6'b100011;
    cyc = 1;
    tick(); cyc++;
    tick(); cyc++;
    checks++; if ({bus.state, bus.alu_src_a, bus.alu_src_b} !== 7'b0010_1_10)
      begin errors++; $display("FAIL lw_memadr got %b want 0010110", {bus.state, bus.alu_src_a, bus.alu_src_b}); end
    tick(); cyc++;
    checks++; if ({bus.state, bus.mem_read, bus.iord} !== 6'b0011_11)
      begin errors++; $display("FAIL lw_memrd got %b want 001111", {bus.state, bus.mem_read, bus.iord}); end
    bus.mem_ready = 1'b0;
    tick(); cyc++;
    tick(); cyc++;
    checks++; if (bus.state !== 4'd3) begin errors++; $display("FAIL lw_memrd_hold got %0d want 3", bus.state); end
    bus.mem_ready = 1'b1;
    tick(); cyc++;
    checks++; if ({bus.state, bus.reg_write, bus.mem_to_reg, bus.reg_dst} !== 7'b0100_110)
      begin errors++; $display("FAIL lw_memwb got %b want 0100110", {bus.state, bus.reg_write, bus.mem_to_reg, bus.reg_dst}); end
    tick();
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL lw_done got %0d want 0", bus.state); end
    checks++; if (cyc !== 7) begin errors++; $display("FAIL lw_cycles got %0d want 7", cyc); end
  endtask

  task automatic test_beq();
    go_fetch();
    bus.opcode = 6'b000100; bus.zero = 1'b1;
    tick(); tick();
    checks++; if (bus.state !== 4'd8) begin errors++; $display("FAIL beq_state got %0d want 8", bus.state); end
    checks++; if ({bus.branch_eq, bus.branch_neq, bus.controle, bus.pc_en, bus.pc_src} !== 9'b10_0110_1_01)
      begin errors++; $display("FAIL beq_taken got %b want 100110101", {bus.branch_eq, bus.branch_neq, bus.controle, bus.pc_en, bus.pc_src}); end
    bus.zero = 1'b0;
    #1;
    checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %b want 0", bus.pc_en); end
    tick();
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL beq_done got %0d want 0", bus.state); end
  endtask

  task automatic test_bne();
    go_fetch();
    bus.opcode = 6'b000101; bus.zero = 1'b1;
    tick(); tick();
`ifdef MC_CTRL_BNE_EN
    checks++; if ({bus.state, bus.branch_eq, bus.branch_neq, bus.pc_en} !== 7'b1000_011)
      begin errors++; $display("FAIL bne_branch got %b want 1000011", {bus.state, bus.branch_eq, bus.branch_neq, bus.pc_en}); end
    tick();
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL bne_done got %0d want 0", bus.state); end
`else
    checks++; if ({bus.state, bus.illegal, bus.branch_neq, bus.pc_en} !== 7'b1100_100)
      begin errors++; $display("FAIL bne_illegal got %b want 1100100", {bus.state, bus.illegal, bus.branch_neq, bus.pc_en}); end
    tick();
    checks++; if ({bus.state, bus.illegal} !== 5'b00000) begin errors++; $display("FAIL bne_pulse got %b want 00000", {bus.state, bus.illegal}); end
`endif
    bus.zero = 1'b0;
  endtask

  task automatic test_addi_jump();
    go_fetch();
    bus.opcode = 6'b001000;
    tick(); tick();
    checks++; if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.controle} !== 11'b1001_1_10_0010)
      begin errors++; $display("FAIL addi_ex got %b want 10011100010", {bus.state, bus.alu_src_a, bus.alu_src_b, bus.controle}); end
    tick();
    checks++; if ({bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 7'b1010_100)
      begin errors++; $display("FAIL addi_wb got %b want 1010100", {bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg}); end
    tick();
    bus.opcode = 6'b000010;
    tick(); tick();
    checks++; if ({bus.state, bus.pc_src, bus.pc_en} !== 7'b1011_10_1)
      begin errors++; $display("FAIL jump got %b want 1011101", {bus.state, bus.pc_src, bus.pc_en}); end
    tick();
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL jump_done got %0d want 0", bus.state); end
  endtask

  task automatic test_sw_reset();
    go_fetch();
    bus.opcode = 6'b101011;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    checks++; if ({bus.state, bus.mem_write, bus.iord, bus.mem_read} !== 7'b0101_110)
      begin errors++; $display("FAIL sw_memwr got %b want 0101110", {bus.state, bus.mem_write, bus.iord, bus.mem_read}); end
    tick();
    checks++; if ({bus.state, bus.mem_write} !== 5'b0101_1) begin errors++; $display("FAIL sw_hold got %b want 01011", {bus.state, bus.mem_write}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({bus.state, bus.mem_write} !== 5'b0000_0) begin errors++; $display("FAIL sw_reset got %b want 00000", {bus.state, bus.mem_write}); end
    tick();
    checks++; if ({bus.state, bus.mem_write} !== 5'b0000_0) begin errors++; $display("FAIL sw_after_reset got %b want 00000", {bus.state, bus.mem_write}); end
    bus.mem_ready = 1'b1;
  endtask

  task automatic measure(input logic [5:0] op, input logic [5:0] fn, output int cyc);
    bus.opcode = op; bus.funct = fn; bus.mem_ready = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.state !== 4'd0 && cyc < 20);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops   [6] = '{6'b000100, 6'b000010, 6'b000000, 6'b001000, 6'b101011, 6'b100011};
    int         cpi   [6] = '{3, 3, 4, 4, 4, 5};
    int         cyc;
    go_fetch();
    for (int i = 0; i < 6; i++) begin
      measure(ops[i], 6'b100010, cyc);
      checks++; if (cyc !== cpi[i]) begin errors++; $display("FAIL cpi_op%b got %0d want %0d", ops[i], cyc, cpi[i]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    test_reset();
    test_fetch_wait();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_bne();
    test_addi_jump();
    test_sw_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control unit for the MIPS datapath: a Moore-style FSM that sequences fetch, decode, execute, memory and writeback and drives the ALU's `controle`, `branch_eq` and `branch_neq` inputs. It consumes the ALU's `zero` flag to qualify branches. It sits between the instruction register (`opcode`, `funct`) and the datapath muxes, register file, PC and memory enables. It waits on a memory ready handshake.

## Interface
- No parameters; widths fixed (6-bit opcode/funct, 4-bit ALU control).
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; next edge forces state FETCH.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU branch-condition result, same cycle.
- `mem_ready` in 1: memory completed access this cycle.
- `controle` out 4: ALU op. AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- `branch_eq`, `branch_neq` out 1 each: ALU compare select.
- `alu_src_a` out 1: 0=PC, 1=rs.
- `alu_src_b` out 2: 00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2.
- `pc_src` out 2: 00=ALU, 01=ALUOut, 10=jump target.
- `pc_en` out 1: PC load.
- `iord`, `mem_read`, `mem_write`, `ir_write` out 1 each: memory/IR control.
- `reg_write`, `reg_dst`, `mem_to_reg` out 1 each: register file control.
- `illegal` out 1: one-cycle pulse on an unsupported instruction.
- `state` out 4: current state encoding, for debug.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7.
  - BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12. Encodings 13–15 go to FETCH.
- FETCH:
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `controle`=0010, `pc_src`=00.
  - `ir_write` = `pc_en` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `controle`=0010 (branch target into ALUOut). Next state by opcode:
  - 000000 with legal funct → EXEC.
  - 100011 (lw) / 101011 (sw) → MEMADR.
  - 000100 (beq) / 000101 (bne) → BRANCH.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JUMP.
  - Anything else → ILLEGAL.
- Legal funct values: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next state FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Holds until `mem_ready`, then FETCH. `mem_write` stays high while waiting.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `controle` from funct. Next state ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `controle` held from EXEC. Next state FETCH.
- BRANCH:
  - `alu_src_a`=1, `alu_src_b`=00, `controle`=0110, `pc_src`=01.
  - `branch_eq`=1 for beq; `branch_neq`=1 for bne.
  - `pc_en`=`zero`, combinational within the same cycle. Next state FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, ADD. ADDIWB: `reg_write`=1, `reg_dst`=0. Then FETCH.
- JUMP: `pc_src`=10, `pc_en`=1. Next state FETCH.
- ILLEGAL: `illegal`=1, no write enables. Next state FETCH; PC already advanced, so the instruction is skipped.
- Default for every output not listed in a state is 0. `controle` defaults to 0010.
- `branch_eq` and `branch_neq` are never both 1.
- `opcode` and `funct` are read only in DECODE, BRANCH, EXEC and ALUWB.

## Timing
- State register updates on the rising edge of `clk`. Outputs decode combinationally from `state`, plus `opcode`/`funct`/`zero`/`mem_ready` as listed.
- Reset has priority over all transitions. Reset asserted in any state, including mid-wait in MEMRD/MEMWR, gives FETCH on the next edge with no partial write completing afterward.
- Reset output values are the FETCH decode: `mem_read`=1, `controle`=0010, `alu_src_b`=01, `state`=0. All write enables are 0 except `ir_write`/`pc_en` following `mem_ready`.
- Cycles per instruction with `mem_ready` held 1: beq/bne/j 3, R-type/addi/sw 4, lw 5. Each `mem_ready` low cycle in FETCH/MEMRD/MEMWR adds one cycle.

## Configuration
- `MC_CTRL_BNE_EN`:
  - Defined: opcode 000101 is decoded as bne.
  - Undefined: 000101 goes to ILLEGAL and `branch_neq` is tied 0.
  - All other behaviour is identical in both builds.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - funct constants;
  - ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR) shared with the ALU.
- Sub-module `alu_op_decode`: combinational funct → {`controle`, `valid`}, used by both DECODE and EXEC.

## Test plan
- Reset held 2 cycles, then released with `mem_ready`=1 → `state`=0, `controle`=0010, `mem_read`=1, `reg_write`=0; DECODE on the next edge.
- R-type funct 100111 → EXEC with `controle`=1100, then ALUWB with `reg_write`=1, `reg_dst`=1; back to FETCH after 4 cycles.
- lw with `mem_ready` low for 2 cycles in MEMRD → MEMRD held 3 cycles, MEMWB `mem_to_reg`=1; 7 cycles total.
- beq with `zero`=1 → BRANCH `branch_eq`=1, `controle`=0110, `pc_en`=1, `pc_src`=01. Repeat with `zero`=0 → `pc_en`=0.
- bne (macro defined) → `branch_neq`=1. Same opcode with macro undefined → ILLEGAL, `illegal` pulses 1 cycle.
- Reset asserted during MEMWR wait → FETCH next edge, `mem_write`=0 from then on.
